// File: rtl/ethpipe_pkg.sv
// ethpipe_pkg: shared constants and types for the GMII RX slot writer.
//   - GMII preamble / SFD byte values
//   - slot header field offsets and the packed 128-bit header layout
//   - RX state encoding
package ethpipe_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned TRUNC_BIT = 16;
  localparam int unsigned TS_LSB    = 64;
  localparam int unsigned HDR_BITS  = 128;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned TS_W      = 64;
  localparam int unsigned DROP_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_SKIP     = 3'd3,
    ST_HDR      = 3'd4
  } rx_state_e;

  // Header as stored at the start of each slot, LSB first in slot word 0.
  typedef struct packed {
    logic [TS_W-1:0]               ts;
    logic [TS_LSB-TRUNC_BIT-2:0]   rsvd;
    logic                          trunc;
    logic [LEN_W-1:0]              len;
  } slot_hdr_t;

endpackage

// File: rtl/slot_ring_ctrl.sv
// slot_ring_ctrl: occupancy tracking for the RX slot ring.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   commit_i      : a filled slot is handed to the consumer (advances wr_ptr)
//   release_i     : the consumer freed the oldest slot (ignored when empty)
//   wr_ptr_o      : slot currently being filled
//   count_o       : committed slots outstanding
//   empty_o/full_o: registered flags derived from count
module slot_ring_ctrl #(
  parameter int unsigned SLOT_NUM = 4,
  localparam int unsigned PTR_W   = $clog2(SLOT_NUM),
  localparam int unsigned CNT_W   = $clog2(SLOT_NUM + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             commit_i,
  input  logic             release_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q;
  logic             rel_ok_c;

  // Pointer/count update; simultaneous commit and release leave count alone.
  always_comb begin
    rel_ok_c = release_i && (count_q != '0);
    wr_ptr_d = commit_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rel_ok_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({commit_i, rel_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_q == '0);
      full_q   <= (count_q == CNT_W'(SLOT_NUM));
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign count_o  = count_q;
  assign empty_o  = empty_q;
  assign full_o   = full_q;

endmodule

// File: rtl/gmii_rx_slot_writer.sv
// gmii_rx_slot_writer: GMII receive path into a ring of RAM slots.
//   sys_clk, sys_rst      : clock, synchronous active-low reset
//   gmii_rxd, gmii_rx_dv  : GMII receive byte stream
//   global_counter        : timestamp latched on the SFD cycle
//   slot_rx_eth_*         : registered slot RAM write port
//   slot_release          : consumer freed the oldest slot
//   rx_complete           : one-cycle pulse when a slot is committed
//   rx_empty, slot_full   : ring occupancy flags
//   drop_cnt              : saturating count of frames dropped for lack of a slot
// Frame bytes are packed little-endian after the header words; the header
// (length, truncation flag, timestamp) is written once the frame ends.
module gmii_rx_slot_writer
  import ethpipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SLOT_NUM   = 4,
  parameter int unsigned SLOT_WORDS = 512,
  localparam int unsigned BYTES     = DATA_W / 8,
  localparam int unsigned HDR_WORDS = HDR_BITS / DATA_W,
  localparam int unsigned ADDR_W    = $clog2(SLOT_NUM * SLOT_WORDS)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [7:0]          gmii_rxd,
  input  logic                gmii_rx_dv,
  input  logic [63:0]         global_counter,
  output logic [DATA_W-1:0]   slot_rx_eth_data,
  output logic [BYTES-1:0]    slot_rx_eth_byte_en,
  output logic [ADDR_W-1:0]   slot_rx_eth_address,
  output logic                slot_rx_eth_wr_en,
  input  logic                slot_release,
  output logic                rx_complete,
  output logic                rx_empty,
  output logic                slot_full,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int unsigned SLOT_W = $clog2(SLOT_NUM);
  localparam int unsigned WORD_W = $clog2(SLOT_WORDS);
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned HIDX_W = $clog2(HDR_WORDS + 1);
  localparam int unsigned CNT_W  = $clog2(SLOT_NUM + 1);
  localparam int unsigned CAP    = (SLOT_WORDS - HDR_WORDS) * BYTES;

  rx_state_e           state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                trunc_q, trunc_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [HIDX_W-1:0]   hdr_idx_q, hdr_idx_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cmpl_q, cmpl_d;

  logic                commit_c;
  logic                sfd_c;
  logic [LANE_W-1:0]   lane_c;
  logic [DATA_W-1:0]   word_n_c;
  logic [ADDR_W-1:0]   data_addr_c;
  slot_hdr_t           hdr_c;
  logic [HDR_BITS-1:0] hdr_vec_c;
  logic [DATA_W-1:0]   hdr_word_c;

  logic [SLOT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                ring_empty;
  logic                ring_full;

  slot_ring_ctrl #(
    .SLOT_NUM (SLOT_NUM)
  ) u_ring (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst),
    .commit_i  (commit_c),
    .release_i (slot_release),
    .wr_ptr_o  (wr_ptr),
    .count_o   (count),
    .empty_o   (ring_empty),
    .full_o    (ring_full)
  );

  // Receive FSM, byte packing and header emission.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    trunc_d   = trunc_q;
    ts_d      = ts_q;
    word_d    = word_q;
    hdr_idx_d = hdr_idx_q;
    drop_d    = drop_q;
    wr_en_d   = 1'b0;
    data_d    = '0;
    be_d      = '0;
    addr_d    = '0;
    cmpl_d    = 1'b0;
    commit_c  = 1'b0;
    sfd_c     = 1'b0;

    lane_c   = len_q[LANE_W-1:0];
    word_n_c = word_q;
    for (int b = 0; b < BYTES; b++) begin
      if (lane_c == LANE_W'(b)) word_n_c[8*b +: 8] = gmii_rxd;
    end
    data_addr_c = {wr_ptr, WORD_W'(HDR_WORDS) + WORD_W'(len_q >> LANE_W)};

    hdr_c       = '0;
    hdr_c.ts    = ts_q;
    hdr_c.trunc = trunc_q;
    hdr_c.len   = len_q;
    hdr_vec_c   = hdr_c;
    hdr_word_c  = '0;
    for (int w = 0; w < HDR_WORDS; w++) begin
      if (hdr_idx_q == HIDX_W'(w)) hdr_word_c = hdr_vec_c[DATA_W*w +: DATA_W];
    end

    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE)  state_d = ST_PREAMBLE;
          else if (gmii_rxd == SFD_BYTE)  sfd_c   = 1'b1;
          else                            state_d = ST_SKIP;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv)                  state_d = ST_IDLE;
        else if (gmii_rxd == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
        else if (gmii_rxd == SFD_BYTE)    sfd_c   = 1'b1;
        else                              state_d = ST_SKIP;
      end
      ST_DATA: begin
        if (gmii_rx_dv) begin
          if (len_q < LEN_W'(CAP)) begin
            len_d = len_q + LEN_W'(1);
            if (lane_c == LANE_W'(BYTES - 1)) begin
              wr_en_d = 1'b1;
              data_d  = word_n_c;
              be_d    = '1;
              addr_d  = data_addr_c;
              word_d  = '0;
            end else begin
              word_d = word_n_c;
            end
          end else begin
            trunc_d = 1'b1;
          end
        end else if (len_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          // Flush a partially filled word with only its valid low lanes enabled.
          if (lane_c != '0) begin
            wr_en_d = 1'b1;
            data_d  = word_q;
            addr_d  = data_addr_c;
            for (int b = 0; b < BYTES; b++) be_d[b] = (LANE_W'(b) < lane_c);
            word_d  = '0;
          end
          hdr_idx_d = '0;
          state_d   = ST_HDR;
        end
      end
      ST_SKIP: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
      end
      ST_HDR: begin
        // One extra cycle after the last header word carries the commit.
        if (hdr_idx_q < HIDX_W'(HDR_WORDS)) begin
          wr_en_d   = 1'b1;
          data_d    = hdr_word_c;
          be_d      = '1;
          addr_d    = {wr_ptr, WORD_W'(hdr_idx_q)};
          hdr_idx_d = hdr_idx_q + HIDX_W'(1);
        end else begin
          commit_c = 1'b1;
          cmpl_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SFD: start a frame if a slot is free, otherwise count a drop.
    if (sfd_c) begin
      if (count == CNT_W'(SLOT_NUM)) begin
        if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        state_d = ST_SKIP;
      end else begin
        ts_d    = global_counter;
        len_d   = '0;
        trunc_d = 1'b0;
        word_d  = '0;
        state_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      trunc_q   <= 1'b0;
      ts_q      <= '0;
      word_q    <= '0;
      hdr_idx_q <= '0;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      be_q      <= '0;
      addr_q    <= '0;
      cmpl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      ts_q      <= ts_d;
      word_q    <= word_d;
      hdr_idx_q <= hdr_idx_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      cmpl_q    <= cmpl_d;
    end
  end

  assign slot_rx_eth_data    = data_q;
  assign slot_rx_eth_byte_en = be_q;
  assign slot_rx_eth_address = addr_q;
  assign slot_rx_eth_wr_en   = wr_en_q;
  assign rx_complete         = cmpl_q;
  assign rx_empty            = ring_empty;
  assign slot_full           = ring_full;
  assign drop_cnt            = drop_q;

endmodule

// File: tb/tb_gmii_rx_slot_writer.sv
// Directed bench for gmii_rx_slot_writer (DATA_W=32, SLOT_NUM=4, SLOT_WORDS=512).
module tb_gmii_rx_slot_writer;

  localparam int SW = 512;
  localparam int HW = 4;
  localparam int CAPB = (SW - HW) * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rel = 1'b0;
  logic [63:0] gc = 64'hA5A5_0000_1234_0000;

  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [10:0] waddr;
  logic        wr_en;
  logic        rx_complete;
  logic        rx_empty;
  logic        slot_full;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) gc <= gc + 64'd1;

  gmii_rx_slot_writer #(
    .DATA_W     (32),
    .SLOT_NUM   (4),
    .SLOT_WORDS (SW)
  ) dut (
    .sys_clk             (clk),
    .sys_rst             (rst_n),
    .gmii_rxd            (rxd),
    .gmii_rx_dv          (rx_dv),
    .global_counter      (gc),
    .slot_rx_eth_data    (wdata),
    .slot_rx_eth_byte_en (wbe),
    .slot_rx_eth_address (waddr),
    .slot_rx_eth_wr_en   (wr_en),
    .slot_release        (rel),
    .rx_complete         (rx_complete),
    .rx_empty            (rx_empty),
    .slot_full           (slot_full),
    .drop_cnt            (drop_cnt)
  );

  // Write/commit log, sampled mid-cycle.
  logic [10:0] log_addr [0:4095];
  logic [31:0] log_data [0:4095];
  logic [3:0]  log_be   [0:4095];
  int          log_cyc  [0:4095];
  int          n_wr = 0;
  int          n_cmp = 0;
  int          cyc = 0;
  int          cmp_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      log_addr[n_wr[11:0]] <= waddr;
      log_data[n_wr[11:0]] <= wdata;
      log_be[n_wr[11:0]]   <= wbe;
      log_cyc[n_wr[11:0]]  <= cyc;
      n_wr <= n_wr + 1;
    end
    if (rx_complete) begin
      n_cmp   <= n_cmp + 1;
      cmp_cyc <= cyc;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_dv = dv;
    rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) drive(1'b0, 8'h00);
  endtask

  task automatic pulse_release();
    @(posedge clk);
    #1 rel = 1'b1;
    @(posedge clk);
    #1 rel = 1'b0;
  endtask

  // Preamble + SFD + payload + gap; optionally raise release on the commit edge.
  task automatic send_frame(input int nbytes, input int seed, input bit rel_at_commit,
                            output logic [63:0] ts);
    bit fired;
    fired = 1'b0;
    for (int p = 0; p < 7; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    ts = gc;
    for (int i = 0; i < nbytes; i++) drive(1'b1, 8'(i + seed));
    drive(1'b0, 8'h00);
    for (int g = 0; g < 12; g++) begin
      drive(1'b0, 8'h00);
      rel = 1'b0;
      if (rel_at_commit && !fired && wr_en && waddr[8:0] == 9'd3) begin
        rel   = 1'b1;
        fired = 1'b1;
      end
    end
    rel = 1'b0;
    if (rel_at_commit) chk("rel_on_commit", 0, 64'(fired), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int start, input int slot, input int nbytes,
                             input int seed, input logic [63:0] ts, input logic trunc);
    int stored, nwd, total, base, i;
    logic [127:0] hdr;
    logic [31:0] ed, m;
    logic [3:0]  eb;
    stored = (nbytes > CAPB) ? CAPB : nbytes;
    nwd    = (stored + 3) / 4;
    total  = nwd + HW;
    base   = slot * SW;
    chk({tag, " nwrites"}, 0, 64'(n_wr - start), 64'(total));
    for (int k = 0; k < nwd; k++) begin
      ed = '0; eb = '0; m = '0;
      for (int b = 0; b < 4; b++) begin
        if (4 * k + b < stored) begin
          ed[8*b +: 8] = 8'(4 * k + b + seed);
          eb[b]        = 1'b1;
          m[8*b +: 8]  = 8'hFF;
        end
      end
      i = (start + k) & 4095;
      chk({tag, " data_addr"}, k, 64'(log_addr[i]), 64'(base + HW + k));
      chk({tag, " data_be"},   k, 64'(log_be[i]),   64'(eb));
      chk({tag, " data"},      k, 64'(log_data[i] & m), 64'(ed));
    end
    hdr = {ts, 47'd0, trunc, 16'(stored)};
    for (int w = 0; w < HW; w++) begin
      i = (start + nwd + w) & 4095;
      chk({tag, " hdr_addr"}, w, 64'(log_addr[i]), 64'(base + w));
      chk({tag, " hdr_be"},   w, 64'(log_be[i]),   64'hF);
      chk({tag, " hdr_data"}, w, 64'(log_data[i]), 64'(hdr[32*w +: 32]));
    end
    chk({tag, " complete_cycle"}, 0, 64'(cmp_cyc), 64'(log_cyc[(start + total - 1) & 4095] + 1));
  endtask

  initial begin
    logic [63:0] ts;
    int s0, c0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst wr_en", 0, 64'(wr_en), 64'd0);
    chk("rst complete", 0, 64'(rx_complete), 64'd0);
    chk("rst empty", 0, 64'(rx_empty), 64'd1);
    chk("rst full", 0, 64'(slot_full), 64'd0);
    chk("rst drop", 0, 64'(drop_cnt), 64'd0);
    chk("rst addr", 0, 64'(waddr), 64'd0);
    chk("rst be", 0, 64'(wbe), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // 64-byte frame into slot 0
    s0 = n_wr; c0 = n_cmp;
    send_frame(64, 0, 1'b0, ts);
    check_frame("A", s0, 0, 64, 0, ts, 1'b0);
    chk("A commits", 0, 64'(n_cmp - c0), 64'd1);
    chk("A empty", 0, 64'(rx_empty), 64'd0);
    chk("A full", 0, 64'(slot_full), 64'd0);

    // 61-byte frame: partial last word, slot 1
    s0 = n_wr;
    send_frame(61, 8'h80, 1'b0, ts);
    check_frame("B", s0, 1, 61, 8'h80, ts, 1'b0);

    // Release coincident with commit at count 2
    s0 = n_wr;
    send_frame(8, 8'h20, 1'b1, ts);
    check_frame("C", s0, 2, 8, 8'h20, ts, 1'b0);
    chk("C full", 0, 64'(slot_full), 64'd0);

    s0 = n_wr;
    send_frame(8, 8'h40, 1'b0, ts);
    check_frame("D", s0, 3, 8, 8'h40, ts, 1'b0);
    chk("D full", 0, 64'(slot_full), 64'd0);

    s0 = n_wr;
    send_frame(8, 8'h60, 1'b0, ts);
    check_frame("E", s0, 0, 8, 8'h60, ts, 1'b0);
    chk("E full", 0, 64'(slot_full), 64'd1);

    // Ring full: frame dropped
    s0 = n_wr; c0 = n_cmp;
    send_frame(16, 0, 1'b0, ts);
    chk("F nwrites", 0, 64'(n_wr - s0), 64'd0);
    chk("F commits", 0, 64'(n_cmp - c0), 64'd0);
    chk("F drop", 0, 64'(drop_cnt), 64'd1);

    pulse_release();
    idle(3);
    chk("rel full", 0, 64'(slot_full), 64'd0);

    s0 = n_wr;
    send_frame(12, 8'hC0, 1'b0, ts);
    check_frame("G", s0, 1, 12, 8'hC0, ts, 1'b0);
    chk("G full", 0, 64'(slot_full), 64'd1);

    pulse_release();
    pulse_release();
    idle(3);

    // Bad preamble byte: frame skipped, no drop counted
    s0 = n_wr; c0 = n_cmp;
    for (int p = 0; p < 3; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'h12);
    for (int p = 0; p < 4; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(i));
    idle(12);
    chk("bad_pre nwrites", 0, 64'(n_wr - s0), 64'd0);
    chk("bad_pre commits", 0, 64'(n_cmp - c0), 64'd0);
    chk("bad_pre drop", 0, 64'(drop_cnt), 64'd1);

    // Oversized frame: truncated at slot capacity, slot 2
    s0 = n_wr;
    send_frame(3000, 8'h07, 1'b0, ts);
    check_frame("T", s0, 2, 3000, 8'h07, ts, 1'b1);

    // Zero-length frame: no writes, no commit
    s0 = n_wr; c0 = n_cmp;
    for (int p = 0; p < 7; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    idle(12);
    chk("zero nwrites", 0, 64'(n_wr - s0), 64'd0);
    chk("zero commits", 0, 64'(n_cmp - c0), 64'd0);
    chk("zero empty", 0, 64'(rx_empty), 64'd0);
    chk("zero full", 0, 64'(slot_full), 64'd0);

    // Reset mid-frame
    for (int p = 0; p < 7; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst wr_en", 0, 64'(wr_en), 64'd0);
    chk("midrst empty", 0, 64'(rx_empty), 64'd1);
    chk("midrst full", 0, 64'(slot_full), 64'd0);
    chk("midrst drop", 0, 64'(drop_cnt), 64'd0);
    s0 = n_wr; c0 = n_cmp;
    rst_n = 1'b1;
    idle(12);
    chk("midrst nwrites", 0, 64'(n_wr - s0), 64'd0);
    chk("midrst commits", 0, 64'(n_cmp - c0), 64'd0);

    // Release while empty is ignored
    pulse_release();
    idle(3);
    chk("rel_empty empty", 0, 64'(rx_empty), 64'd1);

    s0 = n_wr;
    send_frame(8, 8'hE0, 1'b0, ts);
    check_frame("H", s0, 0, 8, 8'hE0, ts, 1'b0);
    chk("H empty", 0, 64'(rx_empty), 64'd0);
    chk("H full", 0, 64'(slot_full), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
